regular_dec: RTL and testbench
==============================

REGULAR_DEC -- requirements
Module: regular_dec

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: i_vl  in  1  sample request valid; i_rdy  out  1  request accepted when i_vl&&i_rdy.
REQ-004 SHALL have ports: i_px  in  8  predicted pixel; i_s  in  1  context sign; i_qh  in  5  context index 0..27.
REQ-005 SHALL have ports: o_kvl  out  1  Golomb parameter valid; o_k  out  4  parameter k 0..13, sent to bit reader.
REQ-006 SHALL have ports: i_cvl  in  1  code valid; i_zc  in  5  unary prefix zero count 0..23; i_bv  in  9  suffix bits, low k bits valid, or low 8 bits when i_zc==23.
REQ-007 SHALL have ports: o_vl  out  1  reconstructed sample valid, 1-cycle pulse; o_x  out  8  reconstructed pixel.
REQ-008 SHALL have parameter LIMIT, default 23, escape prefix length.

Function
REQ-009 SHALL hold per-context arrays N[7b], A[13b], B[signed 7b], C[8b, signed] for 28 contexts.
REQ-010 SHALL use FSM INIT->IDLE->LOOK->WAIT->CALC->DONE->IDLE; i_rdy=1 only in IDLE.
REQ-011 INIT SHALL write N=1, A=4, B=0, C=0 to contexts 0..27, one per cycle, 28 cycles, then enter IDLE.
REQ-012 IDLE SHALL latch i_px, i_s, i_qh on accept and enter LOOK.
REQ-013 LOOK SHALL read the context and compute k = count of ii in 0..12 with (N<<ii) < A; enter WAIT next cycle.
REQ-014 WAIT SHALL drive o_kvl=1, o_k=k until i_cvl=1; transfer on that cycle; i_cvl outside WAIT SHALL be ignored.
REQ-015 CALC SHALL compute merr = (i_zc<<k)|(i_bv mod 2^k) when i_zc<LIMIT, else merr = i_bv[7:0]+1.
REQ-016 Inverse map SHALL apply when k==0 and -2B>=N: merr odd->err=merr>>1, even->err=-(merr>>1)-1; otherwise merr even->err=merr>>1, odd->err=-((merr+1)>>1).
REQ-017 pxc SHALL be i_px+C when s=0 and i_px-C when s=1, clamped to 0..255; o_x SHALL be (pxc+(s?-err:err)) mod 256.
REQ-018 Update SHALL be A=(A+|err|), then halved if N==64; Nn=(N==64?32:N)+1; B'=B+err, halved arithmetically if N==64.
REQ-019 Bias SHALL be: B'<=-Nn -> B'+=Nn, floor at -Nn+1, C-- unless C==-128. B'>0 -> B'-=Nn, ceiling at 0, C++ unless C==127.
REQ-020 DONE SHALL pulse o_vl with o_x, write N,A,B,C back, enter IDLE; total accept-to-o_vl = 3 cycles + WAIT duration.
REQ-021 Back-to-back requests to the same context SHALL see the previous sample's updated state, since there is no overlap.

Reset
REQ-022 rst in any state SHALL force INIT with counter 0 and abort any in-flight sample with no o_vl.
REQ-023 During rst and INIT, outputs SHALL be i_rdy=0, o_kvl=0, o_vl=0, o_k=0, o_x=0.

Configuration
REQ-024 With JLS_DEC_ERRCHK_EN defined, output o_err (1b, sticky until rst) SHALL set when i_zc>LIMIT or merr>255 at CALC, and the sample SHALL still complete.
REQ-025 Without JLS_DEC_ERRCHK_EN, o_err SHALL be absent and i_zc>LIMIT SHALL be treated as escape.

Verification
REQ-026 rst 1 cycle, then release -> i_rdy=0 for 28 cycles, then 1; first request on qh=0 -> o_kvl=1, o_k=2.
REQ-027 fresh qh=0, s=0, px=100, zc=0, bv=0 -> o_x=100; then context 0 holds N=2, A=4, B=0, C=0.
REQ-028 fresh qh=1, s=0, px=100, zc=23, bv=4 -> merr=5, err=-3, o_x=97.
REQ-029 fresh qh=2, s=1, px=200, zc=0, bv=2 -> err=1, o_x=199; fresh qh=3, s=0, px=250, zc=5, bv=0 -> merr=20, o_x=4 (wrap).
REQ-030 i_cvl pulsed during LOOK -> ignored, o_kvl held until a later i_cvl; rst asserted in WAIT -> no o_vl, INIT restarts.
REQ-031 with JLS_DEC_ERRCHK_EN, zc=24 -> o_err=1, holds until rst.

Source files
------------

// File: rtl/regular_dec.sv
// JPEG-LS regular-mode sample decoder: context lookup, Golomb k, error unmap, bias update.
// Optional sticky code-error flag o_err when JLS_DEC_ERRCHK_EN is defined.
module regular_dec #(
    parameter int LIMIT = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vl,
    output logic       i_rdy,
    input  logic [7:0] i_px,
    input  logic       i_s,
    input  logic [4:0] i_qh,
    output logic       o_kvl,
    output logic [3:0] o_k,
    input  logic       i_cvl,
    input  logic [4:0] i_zc,
    input  logic [8:0] i_bv,
    output logic       o_vl,
    output logic [7:0] o_x
`ifdef JLS_DEC_ERRCHK_EN
    ,
    output logic       o_err
`endif
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOK, S_WAIT, S_CALC, S_DONE
    } state_t;

    state_t st_q, st_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] px_q, px_d;
    logic       s_q, s_d;
    logic [4:0] qh_q, qh_d;
    logic [4:0] zc_q, zc_d;
    logic [8:0] bv_q, bv_d;
    logic [3:0] k_q, k_d;
    logic [6:0] n_q, n_d;
    logic [12:0] a_q, a_d;
    logic [6:0] b_q, b_d;
    logic [7:0] c_q, c_d;
    logic [7:0] x_q, x_d;

    logic [6:0]  n_mem [28];
    logic [12:0] a_mem [28];
    logic [6:0]  b_mem [28];
    logic [7:0]  c_mem [28];

    logic [6:0]  rd_n;
    logic [12:0] rd_a;
    logic [6:0]  rd_b;
    logic [7:0]  rd_c;

    assign rd_n = n_mem[qh_q];
    assign rd_a = a_mem[qh_q];
    assign rd_b = b_mem[qh_q];
    assign rd_c = c_mem[qh_q];

    logic [3:0]         k_calc;
    logic               esc;
    logic [23:0]        mask;
    logic [23:0]        merr;
    logic [24:0]        mu, half, halfp;
    logic signed [9:0]  nb2;
    logic               inv;
    logic signed [24:0] err;
    logic [24:0]        aerr;
    logic signed [9:0]  cx, px10, pc;
    logic [7:0]         pcl;
    logic [7:0]         x_calc;
    logic               n64;
    logic [24:0]        asum, ahalf;
    logic [12:0]        a_new;
    logic signed [24:0] bsum, bh, nns, b_fin;
    logic [6:0]         nn;
    logic [7:0]         c_new;
    logic               unused;

    always_comb begin
        k_calc = '0;
        for (int ii = 0; ii < 13; ii++) begin
            if (({13'd0, rd_n} << ii) < {7'd0, rd_a}) begin
                k_calc = k_calc + 4'd1;
            end
        end

        esc  = ({27'd0, zc_q} >= LIMIT);
        mask = (24'd1 << k_q) - 24'd1;
        if (esc) begin
            merr = {15'd0, bv_q[7:0]} + 24'd1;
        end else begin
            merr = ({19'd0, zc_q} << k_q) | ({15'd0, bv_q} & mask);
        end

        mu    = {1'b0, merr};
        half  = mu >> 1;
        halfp = (mu + 25'd1) >> 1;
        nb2   = -($signed({{3{b_q[6]}}, b_q}) <<< 1);
        inv   = (k_q == 4'd0) && (nb2 >= $signed({3'b0, n_q}));
        if (inv) begin
            err = mu[0] ? half : ~half;
        end else begin
            err = mu[0] ? -halfp : half;
        end
        aerr = err[24] ? -err : err;

        cx   = $signed({{2{c_q[7]}}, c_q});
        px10 = $signed({2'b0, px_q});
        pc   = s_q ? px10 - cx : px10 + cx;
        if (pc < 10'sd0) begin
            pcl = 8'd0;
        end else if (pc > 10'sd255) begin
            pcl = 8'd255;
        end else begin
            pcl = pc[7:0];
        end
        x_calc = s_q ? pcl - err[7:0] : pcl + err[7:0];

        // Halving on N==64 renormalises the context and restarts N at 33.
        n64   = (n_q == 7'd64);
        asum  = {12'd0, a_q} + aerr;
        ahalf = n64 ? asum >> 1 : asum;
        a_new = ahalf[12:0];
        nn    = (n64 ? 7'd32 : n_q) + 7'd1;
        nns   = $signed({18'd0, nn});
        bsum  = $signed({{18{b_q[6]}}, b_q}) + err;
        bh    = n64 ? (bsum >>> 1) : bsum;

        b_fin = bh;
        c_new = c_q;
        if (bh <= -nns) begin
            b_fin = bh + nns;
            if (b_fin <= -nns) begin
                b_fin = 25'sd1 - nns;
            end
            if (c_q != 8'h80) begin
                c_new = c_q - 8'd1;
            end
        end else if (bh > 25'sd0) begin
            b_fin = bh - nns;
            if (b_fin > 25'sd0) begin
                b_fin = '0;
            end
            if (c_q != 8'h7f) begin
                c_new = c_q + 8'd1;
            end
        end
    end

    assign unused = ^{ahalf[24:13], b_fin[24:7]};

`ifdef JLS_DEC_ERRCHK_EN
    logic err_q, err_d;
    logic bad;
    assign bad   = ({27'd0, zc_q} > LIMIT) || (merr > 24'd255);
    assign o_err = err_q;
`endif

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        px_d  = px_q;
        s_d   = s_q;
        qh_d  = qh_q;
        zc_d  = zc_q;
        bv_d  = bv_q;
        k_d   = k_q;
        n_d   = n_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        x_d   = x_q;
`ifdef JLS_DEC_ERRCHK_EN
        err_d = err_q;
`endif
        unique case (st_q)
            S_INIT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd27) begin
                    cnt_d = '0;
                    st_d  = S_IDLE;
                end
            end
            S_IDLE: begin
                if (i_vl) begin
                    px_d = i_px;
                    s_d  = i_s;
                    qh_d = i_qh;
                    st_d = S_LOOK;
                end
            end
            S_LOOK: begin
                n_d  = rd_n;
                a_d  = rd_a;
                b_d  = rd_b;
                c_d  = rd_c;
                k_d  = k_calc;
                st_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_cvl) begin
                    zc_d = i_zc;
                    bv_d = i_bv;
                    st_d = S_CALC;
                end
            end
            S_CALC: begin
                x_d  = x_calc;
                n_d  = nn;
                a_d  = a_new;
                b_d  = b_fin[6:0];
                c_d  = c_new;
`ifdef JLS_DEC_ERRCHK_EN
                err_d = err_q | bad;
`endif
                st_d = S_DONE;
            end
            S_DONE: begin
                st_d = S_IDLE;
            end
            default: begin
                st_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_INIT;
            cnt_q <= '0;
            px_q  <= '0;
            s_q   <= 1'b0;
            qh_q  <= '0;
            zc_q  <= '0;
            bv_q  <= '0;
            k_q   <= '0;
            n_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
`ifdef JLS_DEC_ERRCHK_EN
            err_q <= 1'b0;
`endif
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            px_q  <= px_d;
            s_q   <= s_d;
            qh_q  <= qh_d;
            zc_q  <= zc_d;
            bv_q  <= bv_d;
            k_q   <= k_d;
            n_q   <= n_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            x_q   <= x_d;
`ifdef JLS_DEC_ERRCHK_EN
            err_q <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (st_q == S_INIT) begin
                n_mem[cnt_q] <= 7'd1;
                a_mem[cnt_q] <= 13'd4;
                b_mem[cnt_q] <= 7'd0;
                c_mem[cnt_q] <= 8'd0;
            end else if (st_q == S_DONE) begin
                n_mem[qh_q] <= n_q;
                a_mem[qh_q] <= a_q;
                b_mem[qh_q] <= b_q;
                c_mem[qh_q] <= c_q;
            end
        end
    end

    assign i_rdy = (st_q == S_IDLE);
    assign o_kvl = (st_q == S_WAIT);
    assign o_vl  = (st_q == S_DONE);
    assign o_k   = k_q;
    assign o_x   = x_q;

endmodule

// File: tb/tb_regular_dec.sv
// Randomized bench for regular_dec against a plain-arithmetic context model.
module tb_regular_dec;

    localparam int LIM = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_vl = 1'b0;
    logic       i_rdy;
    logic [7:0] i_px = '0;
    logic       i_s = 1'b0;
    logic [4:0] i_qh = '0;
    logic       o_kvl;
    logic [3:0] o_k;
    logic       i_cvl = 1'b0;
    logic [4:0] i_zc = '0;
    logic [8:0] i_bv = '0;
    logic       o_vl;
    logic [7:0] o_x;
`ifdef JLS_DEC_ERRCHK_EN
    logic       o_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mN[28];
    int mA[28];
    int mB[28];
    int mC[28];

    always #5 clk = ~clk;

    regular_dec #(.LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .i_vl(i_vl), .i_rdy(i_rdy),
        .i_px(i_px), .i_s(i_s), .i_qh(i_qh),
        .o_kvl(o_kvl), .o_k(o_k),
        .i_cvl(i_cvl), .i_zc(i_zc), .i_bv(i_bv),
        .o_vl(o_vl), .o_x(o_x)
`ifdef JLS_DEC_ERRCHK_EN
        , .o_err(o_err)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < 28; i++) begin
            mN[i] = 1; mA[i] = 4; mB[i] = 0; mC[i] = 0;
        end
    endfunction

    function automatic int model_k(int q);
        int k = 0;
        for (int ii = 0; ii < 13; ii++)
            if ((mN[q] << ii) < mA[q]) k++;
        return k;
    endfunction

    // One sample through the context: returns the pixel and updates N/A/B/C.
    function automatic int model_step(int q, int px, int s, int zc, int bv);
        int k, merr, err, pxc, x, nn, bp;
        k = model_k(q);
        if (zc < LIM) merr = (zc << k) | (bv & ((1 << k) - 1));
        else merr = (bv & 255) + 1;
        if (k == 0 && -2 * mB[q] >= mN[q])
            err = (merr % 2 == 1) ? (merr / 2) : -(merr / 2) - 1;
        else
            err = (merr % 2 == 0) ? (merr / 2) : -((merr + 1) / 2);
        pxc = s ? px - mC[q] : px + mC[q];
        if (pxc < 0) pxc = 0;
        if (pxc > 255) pxc = 255;
        x = (pxc + (s ? -err : err)) & 255;
        mA[q] = ((mA[q] + (err < 0 ? -err : err)) >> (mN[q] == 64 ? 1 : 0)) & 8191;
        bp = mB[q] + err;
        if (mN[q] == 64) bp = bp >>> 1;
        nn = (mN[q] == 64 ? 32 : mN[q]) + 1;
        if (bp <= -nn) begin
            bp += nn;
            if (bp <= -nn) bp = -nn + 1;
            if (mC[q] > -128) mC[q]--;
        end else if (bp > 0) begin
            bp -= nn;
            if (bp > 0) bp = 0;
            if (mC[q] < 127) mC[q]++;
        end
        mB[q] = bp;
        mN[q] = nn;
        return x;
    endfunction

    task automatic do_reset();
        int cyc;
        int noisy;
        rst = 1'b1;
        i_vl = 1'b0;
        @(negedge clk);
        check("rst_rdy", i_rdy, 0);
        check("rst_kvl", o_kvl, 0);
        check("rst_vl", o_vl, 0);
        check("rst_k", o_k, 0);
        check("rst_x", o_x, 0);
        rst = 1'b0;
        model_init();
        cyc = 0;
        noisy = 0;
        while (!i_rdy && cyc < 100) begin
            if (o_vl || o_kvl || o_k != 0 || o_x != 0) noisy = 1;
            cyc++;
            @(negedge clk);
        end
        check("init_cycles", cyc, 28);
        check("init_quiet", noisy, 0);
        i_cvl = 1'b0;
    endtask

    task automatic run_sample(input int px, input int s, input int qh,
                              input int zc, input int bv, input int wdly,
                              input bit spur, output int ko, output int xo);
        int t, ek, ex;
        t = 0;
        while (!i_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rdy_wait", i_rdy, 1);
        ek = model_k(qh);
        i_vl = 1'b1;
        i_px = px[7:0];
        i_s = s[0];
        i_qh = qh[4:0];
        @(negedge clk);
        i_vl = 1'b0;
        check("look_rdy", i_rdy, 0);
        if (spur) begin
            i_cvl = 1'b1;
            i_zc = 5'd31;
            i_bv = 9'h1ff;
        end
        @(negedge clk);
        i_cvl = 1'b0;
        for (int w = 0; w < wdly; w++) @(negedge clk);
        check("kvl", o_kvl, 1);
        check("k", o_k, ek);
        ko = int'(o_k);
        i_cvl = 1'b1;
        i_zc = zc[4:0];
        i_bv = bv[8:0];
        @(negedge clk);
        i_cvl = 1'b0;
        check("calc_vl", o_vl, 0);
        @(negedge clk);
        check("vl", o_vl, 1);
        ex = model_step(qh, px, s, zc, bv);
        check("x", o_x, ex);
        xo = int'(o_x);
        @(negedge clk);
        check("vl_pulse", o_vl, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ko, xo, qh, zc, r;
        do_reset();

        run_sample(100, 0, 0, 0, 0, 0, 0, ko, xo);
        check("d_first_k", ko, 2);
        check("d_ctx0_x", xo, 100);
        run_sample(50, 0, 0, 0, 0, 0, 0, ko, xo);
        check("d_ctx0_k_after", ko, 1);
        run_sample(100, 0, 1, 23, 4, 1, 0, ko, xo);
        check("d_escape_x", xo, 97);
        run_sample(200, 1, 2, 0, 2, 0, 0, ko, xo);
        check("d_neg_sign_x", xo, 199);
        run_sample(250, 0, 3, 5, 0, 2, 0, ko, xo);
        check("d_wrap_x", xo, 4);
        run_sample(30, 1, 5, 1, 3, 2, 1, ko, xo);
        check("d_spur_k", ko, 2);

        for (int n = 0; n < 400; n++) begin
            qh = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 27)
                                             : $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 6) zc = $urandom_range(0, 2);
            else if (r < 8) zc = $urandom_range(0, 22);
            else zc = $urandom_range(23, 31);
            run_sample($urandom_range(0, 255), $urandom_range(0, 1), qh, zc,
                       $urandom_range(0, 511), $urandom_range(0, 2),
                       ($urandom_range(0, 7) == 0), ko, xo);
        end

`ifdef JLS_DEC_ERRCHK_EN
        check("err_clear", o_err, 0);
        run_sample(10, 0, 6, 24, 7, 0, 0, ko, xo);
        check("err_set", o_err, 1);
        repeat (5) @(negedge clk);
        check("err_sticky", o_err, 1);
`endif

        // Abort a sample waiting for its code, with a code valid pending.
        while (!i_rdy) @(negedge clk);
        i_vl = 1'b1;
        i_qh = 5'd7;
        @(negedge clk);
        i_vl = 1'b0;
        @(negedge clk);
        check("abort_kvl", o_kvl, 1);
        i_cvl = 1'b1;
        do_reset();
`ifdef JLS_DEC_ERRCHK_EN
        check("err_rst", o_err, 0);
`endif
        run_sample(100, 0, 0, 0, 0, 0, 0, ko, xo);
        check("post_rst_k", ko, 2);
        check("post_rst_x", xo, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
